// File: rtl/round_sat_pkg.sv
// Shared types and rounding-constant helper for the round_sat_pipe narrowing stage.
package round_sat_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_AWAY = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_HALF_UP   = 2'd3
    } rnd_mode_e;

    // Constant added before dropping d LSBs; callers keep the low IN_W+1 bits.
    function automatic logic [63:0] rnd_const(rnd_mode_e mode, logic sign, logic bit_d,
                                              int unsigned d);
        logic [63:0] h;
        h = 64'd1 << (d - 1);
        case (mode)
            RND_TRUNC:     rnd_const = 64'd0;
            RND_HALF_AWAY: rnd_const = sign ? h - 64'd1 : h;
            RND_HALF_EVEN: rnd_const = h - 64'd1 + {63'd0, bit_d};
            RND_HALF_UP:   rnd_const = h;
            default:       rnd_const = 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/round_sat_pipe_if.sv
// Handshake and data bundle for round_sat_pipe; master drives samples, slave is the DUT.
interface round_sat_pipe_if #(
    parameter int IN_W     = 35,
    parameter int OUT_W    = 17,
    parameter int CHANNELS = 1
);
    logic [CHANNELS*IN_W-1:0]  Data_i;
    logic [1:0]                Mode_i;
    logic                      Valid_i;
    logic                      Ready_o;
    logic [CHANNELS*OUT_W-1:0] Data_o;
    logic                      Valid_o;
    logic                      Ready_i;
    logic [CHANNELS-1:0]       Ovf_o;
    logic                      OvfClr_i;

    modport master (
        output Data_i, Mode_i, Valid_i, Ready_i, OvfClr_i,
        input  Ready_o, Data_o, Valid_o, Ovf_o
    );

    modport slave (
        input  Data_i, Mode_i, Valid_i, Ready_i, OvfClr_i,
        output Ready_o, Data_o, Valid_o, Ovf_o
    );
endinterface

// File: rtl/round_sat_lane.sv
// One channel: stage-1 rounding add, stage-2 saturate (ROUND_SAT_SATURATE_EN) or wrap.
module round_sat_lane
    import round_sat_pkg::*;
#(
    parameter int IN_W  = 35,
    parameter int OUT_W = 17
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             s1_en_i,
    input  logic             s2_en_i,
    input  logic [IN_W-1:0]  sample_i,
    input  rnd_mode_e        mode_i,
    output logic [OUT_W-1:0] data_o
`ifdef ROUND_SAT_SATURATE_EN
    ,
    output logic             ovf_o
`endif
);
    localparam int D = IN_W - OUT_W;

    logic [63:0]     rnd_k;
    logic [IN_W:0]   sum;
    logic [OUT_W:0]  s1_top_q, s1_top_d;
    logic [OUT_W-1:0] s2_data_q, s2_data_d;
    logic            ovf;
    logic            unused_bits;

    // Only the top OUT_W+1 bits of the sum survive the shift, so only they are stored.
    always_comb begin
        rnd_k    = rnd_const(mode_i, sample_i[IN_W-1], sample_i[D], D);
        sum      = {sample_i[IN_W-1], sample_i} + rnd_k[IN_W:0];
        s1_top_d = s1_en_i ? sum[IN_W:D] : s1_top_q;
        ovf      = s1_top_q[OUT_W] ^ s1_top_q[OUT_W-1];
        s2_data_d = s2_data_q;
        if (s2_en_i) begin
`ifdef ROUND_SAT_SATURATE_EN
            if (ovf)
                s2_data_d = s1_top_q[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
            else
                s2_data_d = s1_top_q[OUT_W-1:0];
`else
            s2_data_d = s1_top_q[OUT_W-1:0];
`endif
        end
    end

`ifdef ROUND_SAT_SATURATE_EN
    assign ovf_o       = ovf;
    assign unused_bits = ^{sum[D-1:0], rnd_k[63:IN_W+1]};
`else
    assign unused_bits = ^{sum[D-1:0], rnd_k[63:IN_W+1], ovf};
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_top_q  <= '0;
            s2_data_q <= '0;
        end else begin
            s1_top_q  <= s1_top_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign data_o = s2_data_q;
endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage multi-channel round/saturate pipe with valid/ready backpressure.
// Saturation and sticky Ovf_o are enabled by ROUND_SAT_SATURATE_EN; otherwise results wrap.
module round_sat_pipe
    import round_sat_pkg::*;
#(
    parameter int IN_W     = 35,
    parameter int OUT_W    = 17,
    parameter int CHANNELS = 1
) (
    input logic              Clk_i,
    input logic              Rstn_i,
    round_sat_pipe_if.slave  bus
);
    logic      s1_valid_q, s1_valid_d;
    logic      s2_valid_q, s2_valid_d;
    logic      s1_load, s2_load;
    logic      s1_en, s2_en;
    rnd_mode_e mode;

    wire [OUT_W-1:0] lane_data [CHANNELS];

    // Ready_o is combinational from Ready_i: no skid buffer behind stage 1.
    always_comb begin
        mode       = rnd_mode_e'(bus.Mode_i);
        s2_load    = !s2_valid_q || bus.Ready_i;
        s1_load    = !s1_valid_q || s2_load;
        s1_en      = s1_load && bus.Valid_i;
        s2_en      = s2_load && s1_valid_q;
        s1_valid_d = s1_load ? bus.Valid_i : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign bus.Ready_o = s1_load;
    assign bus.Valid_o = s2_valid_q;

`ifdef ROUND_SAT_SATURATE_EN
    wire                 lane_ovf [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        round_sat_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
            .clk_i    (Clk_i),
            .rstn_i   (Rstn_i),
            .s1_en_i  (s1_en),
            .s2_en_i  (s2_en),
            .sample_i (bus.Data_i[g*IN_W +: IN_W]),
            .mode_i   (mode),
            .data_o   (lane_data[g])
`ifdef ROUND_SAT_SATURATE_EN
            ,
            .ovf_o    (lane_ovf[g])
`endif
        );
    end

    always_comb begin
        bus.Data_o = '0;
        for (int i = 0; i < CHANNELS; i++)
            bus.Data_o[i*OUT_W +: OUT_W] = lane_data[i];
    end

`ifdef ROUND_SAT_SATURATE_EN
    // A set landing in the same cycle as a clear survives.
    always_comb begin
        ovf_d = ovf_q & ~{CHANNELS{bus.OvfClr_i}};
        for (int i = 0; i < CHANNELS; i++)
            if (s2_en && lane_ovf[i]) ovf_d[i] = 1'b1;
    end

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) ovf_q <= '0;
        else         ovf_q <= ovf_d;
    end

    assign bus.Ovf_o = ovf_q;
`else
    logic unused_clr;
    assign unused_clr = bus.OvfClr_i;
    assign bus.Ovf_o  = '0;
`endif
endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed self-checking bench for round_sat_pipe at IN_W=16, OUT_W=8, CHANNELS=2.
module tb_round_sat_pipe;
    localparam int IN_W = 16;
    localparam int OUT_W = 8;
    localparam int CH = 2;

`ifdef ROUND_SAT_SATURATE_EN
    localparam logic [7:0] OVF_OUT  = 8'h7F;
    localparam logic [1:0] OVF_FLAG = 2'b01;
`else
    localparam logic [7:0] OVF_OUT  = 8'h80;
    localparam logic [1:0] OVF_FLAG = 2'b00;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    round_sat_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH)) bus ();

    round_sat_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH)) dut (
        .Clk_i  (clk),
        .Rstn_i (rstn),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [1:0]  eovf;
    } vec_t;

    vec_t vecs[8];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Drive one beat with Ready_i high, return cycles from acceptance edge to Valid_o.
    task automatic run_beat(input logic [1:0] mode, input logic [15:0] d0,
                            input logic [15:0] d1, output int lat);
        @(negedge clk);
        bus.Valid_i = 1'b1;
        bus.Mode_i  = mode;
        bus.Data_i  = {d1, d0};
        #1;
        chk("beat_ready", 32'(bus.Ready_o), 32'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) bus.Valid_i = 1'b0;
            lat++;
        end while (!bus.Valid_o && lat < 10);
    endtask

    initial begin
        int          lat;
        int          acc_n, del_n, c;
        bit          prev_stall, low_seen;
        logic [15:0] prev_data;
        logic [7:0]  x0, x1;

        vecs[0] = '{"m1_basic",    2'd1, 16'h0180, 16'hFE80, 8'h02,   8'hFE, 2'b00};
        vecs[1] = '{"m2_even",     2'd2, 16'h0280, 16'h0380, 8'h02,   8'h04, 2'b00};
        vecs[2] = '{"m0_trunc",    2'd0, 16'hFE80, 16'h0180, 8'hFE,   8'h01, 2'b00};
        vecs[3] = '{"m3_up",       2'd3, 16'hFE80, 16'h0180, 8'hFF,   8'h02, 2'b00};
        vecs[4] = '{"m0_minmax",   2'd0, 16'h8000, 16'h7F00, 8'h80,   8'h7F, 2'b00};
        vecs[5] = '{"m2_min",      2'd2, 16'h8000, 16'h0080, 8'h80,   8'h00, 2'b00};
        vecs[6] = '{"m1_ovf",      2'd1, 16'h7FF0, 16'h0000, OVF_OUT, 8'h00, OVF_FLAG};
        vecs[7] = '{"m1_sticky",   2'd1, 16'h0100, 16'h8000, 8'h01,   8'h80, OVF_FLAG};

        bus.Valid_i  = 1'b0;
        bus.Mode_i   = 2'd0;
        bus.Data_i   = '0;
        bus.Ready_i  = 1'b1;
        bus.OvfClr_i = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.Valid_o), 32'd0);
        chk("rst_data",  32'(bus.Data_o),  32'd0);
        chk("rst_ovf",   32'(bus.Ovf_o),   32'd0);
        chk("rst_ready", 32'(bus.Ready_o), 32'd1);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            run_beat(vecs[i].mode, vecs[i].d0, vecs[i].d1, lat);
            chk({vecs[i].name, "_lat"},  32'(lat),                32'd2);
            chk({vecs[i].name, "_ch0"},  32'(bus.Data_o[7:0]),    32'(vecs[i].e0));
            chk({vecs[i].name, "_ch1"},  32'(bus.Data_o[15:8]),   32'(vecs[i].e1));
            chk({vecs[i].name, "_ovf"},  32'(bus.Ovf_o),          32'(vecs[i].eovf));
        end

        // Clear pulse drops the sticky flag.
        @(negedge clk) bus.OvfClr_i = 1'b1;
        @(negedge clk) bus.OvfClr_i = 1'b0;
        chk("ovf_clear", 32'(bus.Ovf_o), 32'd0);

        // Clear asserted on the very edge stage 2 loads an overflow: set wins.
        @(negedge clk);
        bus.Valid_i = 1'b1;
        bus.Mode_i  = 2'd1;
        bus.Data_i  = {16'h0000, 16'h7FF0};
        @(negedge clk);
        bus.Valid_i  = 1'b0;
        bus.OvfClr_i = 1'b1;
        @(negedge clk);
        bus.OvfClr_i = 1'b0;
        chk("setwins_valid", 32'(bus.Valid_o),     32'd1);
        chk("setwins_data",  32'(bus.Data_o[7:0]), 32'(OVF_OUT));
        chk("setwins_ovf",   32'(bus.Ovf_o),       32'(OVF_FLAG));

        // Ten back-to-back beats with Ready_i low during cycles 3..6.
        acc_n = 0; del_n = 0; c = 0; prev_stall = 0; low_seen = 0; prev_data = '0;
        bus.Mode_i = 2'd0;
        while (del_n < 10 && c < 60) begin
            @(negedge clk);
            bus.Ready_i = !(c >= 3 && c <= 6);
            bus.Valid_i = (acc_n < 10);
            x0 = 8'(acc_n + 1);
            x1 = 8'(0 - (acc_n + 1));
            bus.Data_i = {x1, 8'h00, x0, 8'h00};
            #1;
            chk("stream_ready", 32'(bus.Ready_o), 32'((acc_n - del_n < 2) || bus.Ready_i));
            if (!bus.Ready_o) low_seen = 1;
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.Valid_o), 32'd1);
                chk("stall_data",  32'(bus.Data_o),  32'(prev_data));
            end
            if (bus.Valid_o && bus.Ready_i) begin
                x0 = 8'(del_n + 1);
                x1 = 8'(0 - (del_n + 1));
                chk("stream_order", 32'(bus.Data_o), 32'({x1, x0}));
                del_n++;
            end
            prev_stall = bus.Valid_o && !bus.Ready_i;
            prev_data  = bus.Data_o;
            if (bus.Valid_i && bus.Ready_o) acc_n++;
            c++;
        end
        chk("stream_count",  32'(del_n),    32'd10);
        chk("stream_accept", 32'(acc_n),    32'd10);
        chk("stream_stall",  32'(low_seen), 32'd1);
        bus.Valid_i = 1'b0;
        bus.Ready_i = 1'b1;
        @(negedge clk);
        chk("stream_drained", 32'(bus.Valid_o), 32'd0);

        // Mid-stream reset with two beats in flight; Ovf_o is set beforehand.
        run_beat(2'd1, 16'h7FF0, 16'h0000, lat);
        @(negedge clk);
        bus.Valid_i = 1'b1;
        bus.Mode_i  = 2'd0;
        bus.Data_i  = {16'h0300, 16'h0200};
        @(negedge clk);
        bus.Data_i  = {16'h0500, 16'h0400};
        @(negedge clk);
        bus.Valid_i = 1'b0;
        chk("inflight_valid", 32'(bus.Valid_o), 32'd1);
        chk("inflight_ovf",   32'(bus.Ovf_o),   32'(OVF_FLAG));
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.Valid_o), 32'd0);
        chk("midrst_ovf",   32'(bus.Ovf_o),   32'd0);
        chk("midrst_ready", 32'(bus.Ready_o), 32'd1);
        chk("midrst_data",  32'(bus.Data_o),  32'd0);
        @(negedge clk) rstn = 1'b1;
        run_beat(2'd3, 16'hFE80, 16'h0180, lat);
        chk("postrst_lat",  32'(lat),          32'd2);
        chk("postrst_data", 32'(bus.Data_o),   32'h02FF);
        @(negedge clk);
        chk("postrst_drain", 32'(bus.Valid_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
